// File: rtl/pdata_seq.sv
// pdata_seq: host-side sequencer for one bit-serial pdata processing element.
//
// A parallel command (operands A/B, MUL or MUL_ADD, optional readback) is
// serialised into the PE: A goes to data_1 and B goes to data_2, LSB first.
// The arithmetic opcode is issued next. When requested, the PE accumulator
// is then deserialised back into `result`.
//
// Parameters:
//   SIZE   operand width, must match the attached PE
//   ACC_W  accumulator / result width
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 command request, accepted only while busy=0
//   cmd_acc               0 = MUL, 1 = MUL_ADD (sampled at accept)
//   cmd_read              1 = read accumulator back (sampled at accept)
//   a_in, b_in            operands (sampled at accept)
//   busy                  high in every non-IDLE state
//   done                  one-cycle pulse in the last busy cycle
//   result                last read-back accumulator value
//   echo_a, echo_b        previous PE data_1 / data_2 contents (optional)
//   pe_opcode, pe_rx      registered opcode and serial data to the PE
//   pe_tx                 serial data from the PE (Z while opcode is NO_OP)
//
// Optional feature: define PDATA_SEQ_ECHO_EN to capture the old PE operands
// that stream out on pe_tx during loading. Without it, echo_a/echo_b read 0.
module pdata_seq #(
  parameter int unsigned SIZE  = 32,
  parameter int unsigned ACC_W = 4 * SIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmd_acc,
  input  logic             cmd_read,
  input  logic [SIZE-1:0]  a_in,
  input  logic [SIZE-1:0]  b_in,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] result,
  output logic [SIZE-1:0]  echo_a,
  output logic [SIZE-1:0]  echo_b,
  output logic [2:0]       pe_opcode,
  output logic             pe_rx,
  input  logic             pe_tx
);

  localparam int unsigned CNT_W  = $clog2(ACC_W + 1);
  localparam int unsigned IDX_W  = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int unsigned RIDX_W = (ACC_W > 1) ? $clog2(ACC_W) : 1;

  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(SIZE - 1);
  localparam logic [CNT_W-1:0] READ_LAST = CNT_W'(ACC_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD1,
    S_LOAD2,
    S_MATH,
    S_READ,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_OUT_DATA1 = 3'd0,
    OP_OUT_DATA2 = 3'd1,
    OP_OUT_RES   = 3'd2,
    OP_MUL       = 3'd5,
    OP_MUL_ADD   = 3'd6,
    OP_NO_OP     = 3'd7
  } opcode_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SIZE-1:0]  a_q, a_d;
  logic [SIZE-1:0]  b_q, b_d;
  logic             acc_q, acc_d;
  logic             rd_q, rd_d;
  logic [ACC_W-1:0] sr_q, sr_d;
  logic [ACC_W-1:0] result_q, result_d;
  opcode_e          op_q, op_d;
  logic             rx_q, rx_d;

  logic sample_en;
  logic tx_bit;
  logic load_last;

  // pe_tx may be Z/X outside the phases in which the PE actively drives it;
  // gating it here keeps that from reaching any register.
  assign sample_en = (state_q == S_LOAD1) || (state_q == S_LOAD2) || (state_q == S_READ);
  assign tx_bit    = pe_tx & sample_en;
  assign load_last = (cnt_q == LOAD_LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    rd_d     = rd_q;
    sr_d     = sr_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          acc_d   = cmd_acc;
          rd_d    = cmd_read;
          cnt_d   = '0;
          state_d = S_LOAD1;
        end
      end
      S_LOAD1: begin
        if (load_last) begin
          cnt_d   = '0;
          state_d = S_LOAD2;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LOAD2: begin
        if (load_last) begin
          cnt_d   = '0;
          state_d = S_MATH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_MATH: begin
        cnt_d   = '0;
        state_d = rd_q ? S_READ : S_DONE;
      end
      S_READ: begin
        // Writing bit k in read cycle k gives the same final word as a
        // right shift of pe_tx into the MSB over ACC_W cycles.
        sr_d[cnt_q[RIDX_W-1:0]] = tx_bit;
        if (cnt_q == READ_LAST) begin
          result_d = sr_d;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // PE-facing outputs are registered, so they are derived from the state and
  // counter values that become current at the next edge.
  always_comb begin
    op_d = OP_NO_OP;
    rx_d = 1'b0;
    case (state_d)
      S_LOAD1: begin
        op_d = OP_OUT_DATA1;
        rx_d = a_d[cnt_d[IDX_W-1:0]];
      end
      S_LOAD2: begin
        op_d = OP_OUT_DATA2;
        rx_d = b_d[cnt_d[IDX_W-1:0]];
      end
      S_MATH:  op_d = acc_d ? OP_MUL_ADD : OP_MUL;
      S_READ:  op_d = OP_OUT_RES;
      default: op_d = OP_NO_OP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= 1'b0;
      rd_q     <= 1'b0;
      sr_q     <= '0;
      result_q <= '0;
      op_q     <= OP_NO_OP;
      rx_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      rd_q     <= rd_d;
      sr_q     <= sr_d;
      result_q <= result_d;
      op_q     <= op_d;
      rx_q     <= rx_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign pe_opcode = op_q;
  assign pe_rx     = rx_q;

`ifdef PDATA_SEQ_ECHO_EN
  logic [SIZE-1:0] cap_q, cap_d;
  logic [SIZE-1:0] echo_a_q, echo_a_d;
  logic [SIZE-1:0] echo_b_q, echo_b_d;

  // While an operand is being shifted in, the PE streams out the old value
  // LSB first; one capture register serves both load phases.
  always_comb begin
    cap_d    = cap_q;
    echo_a_d = echo_a_q;
    echo_b_d = echo_b_q;
    if ((state_q == S_LOAD1) || (state_q == S_LOAD2)) begin
      cap_d[cnt_q[IDX_W-1:0]] = tx_bit;
      if (load_last) begin
        if (state_q == S_LOAD1) begin
          echo_a_d = cap_d;
        end else begin
          echo_b_d = cap_d;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q    <= '0;
      echo_a_q <= '0;
      echo_b_q <= '0;
    end else begin
      cap_q    <= cap_d;
      echo_a_q <= echo_a_d;
      echo_b_q <= echo_b_d;
    end
  end

  assign echo_a = echo_a_q;
  assign echo_b = echo_b_q;
`else
  assign echo_a = '0;
  assign echo_b = '0;
`endif

endmodule

// File: tb/tb_pdata_seq.sv
module tb_pdata_seq;

  localparam int unsigned S  = 8;
  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          cmd_acc;
  logic          cmd_read;
  logic [S-1:0]  a_in;
  logic [S-1:0]  b_in;
  logic          busy;
  logic          done;
  logic [AW-1:0] result;
  logic [S-1:0]  echo_a;
  logic [S-1:0]  echo_b;
  logic [2:0]    pe_opcode;
  logic          pe_rx;
  wire           pe_tx;

  pdata_seq #(.SIZE(S), .ACC_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cmd_acc   (cmd_acc),
    .cmd_read  (cmd_read),
    .a_in      (a_in),
    .b_in      (b_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .echo_a    (echo_a),
    .echo_b    (echo_b),
    .pe_opcode (pe_opcode),
    .pe_rx     (pe_rx),
    .pe_tx     (pe_tx)
  );

  always #5 clk = ~clk;

  // Behavioural pdata element.
  logic [S-1:0]  pe_d1  = '0;
  logic [S-1:0]  pe_d2  = '0;
  logic [AW-1:0] pe_acc = '0;

  assign pe_tx = (pe_opcode == 3'd0) ? pe_d1[0] :
                 (pe_opcode == 3'd1) ? pe_d2[0] :
                 (pe_opcode == 3'd2) ? pe_acc[0] :
                 (pe_opcode == 3'd7) ? 1'bz : 1'b0;

  always @(posedge clk) begin
    case (pe_opcode)
      3'd0: pe_d1 <= {pe_rx, pe_d1[S-1:1]};
      3'd1: pe_d2 <= {pe_rx, pe_d2[S-1:1]};
      3'd2: pe_acc <= pe_acc >> 1;
      3'd5: pe_acc <= AW'(pe_d1) * AW'(pe_d2);
      3'd6: pe_acc <= pe_acc + AW'(pe_d1) * AW'(pe_d2);
      default: ;
    endcase
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Command-level model: position inside the busy window plus arithmetic.
  int            m_t     = 0;
  int            m_total = 0;
  logic [S-1:0]  m_a     = '0;
  logic [S-1:0]  m_b     = '0;
  bit            m_acc   = 0;
  bit            m_rd    = 0;
  logic [AW-1:0] m_pacc  = '0;
  bit            pacc_ok = 1;
  logic [S-1:0]  m_d1    = '0;
  logic [S-1:0]  m_d2    = '0;
  bit            d1_ok   = 1;
  bit            d2_ok   = 1;
  logic [AW-1:0] e_res   = '0;
  bit            res_ok  = 1;
  logic [S-1:0]  e_ea    = '0;
  logic [S-1:0]  e_eb    = '0;
  bit            ea_ok   = 1;
  bit            eb_ok   = 1;
  bit            chk_en  = 0;

  always @(posedge clk) begin
    if (rst) begin
      if (m_t >= 1 && m_t <= S) d1_ok = 0;
      else if (m_t > S && m_t <= 2 * S) d2_ok = 0;
      else if (m_t > 2 * S && m_t < m_total) pacc_ok = 0;
      m_t    = 0;
      e_res  = '0;
      res_ok = 1;
      e_ea   = '0;
      e_eb   = '0;
      ea_ok  = 1;
      eb_ok  = 1;
    end else if (m_t == 0) begin
      if (start) begin
        m_a     = a_in;
        m_b     = b_in;
        m_acc   = cmd_acc;
        m_rd    = cmd_read;
        m_total = 2 * S + 1 + (cmd_read ? AW : 0) + 1;
        m_t     = 1;
      end
    end else begin
      if (m_t == S) begin
`ifdef PDATA_SEQ_ECHO_EN
        e_ea  = m_d1;
        ea_ok = d1_ok;
`endif
        m_d1  = m_a;
        d1_ok = 1;
      end
      if (m_t == 2 * S) begin
`ifdef PDATA_SEQ_ECHO_EN
        e_eb  = m_d2;
        eb_ok = d2_ok;
`endif
        m_d2  = m_b;
        d2_ok = 1;
      end
      if (m_t == 2 * S + 1) begin
        if (m_acc) m_pacc = m_pacc + AW'(m_a) * AW'(m_b);
        else begin
          m_pacc  = AW'(m_a) * AW'(m_b);
          pacc_ok = 1;
        end
      end
      if (m_rd && m_t == 2 * S + 1 + AW) begin
        e_res   = m_pacc;
        res_ok  = pacc_ok;
        m_pacc  = '0;
        pacc_ok = 1;
      end
      if (m_t == m_total) m_t = 0;
      else m_t++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int t;
      logic [2:0] eop;
      logic erx;
      t = m_t;
      if (t == 0 || t == m_total) eop = 3'd7;
      else if (t <= S) eop = 3'd0;
      else if (t <= 2 * S) eop = 3'd1;
      else if (t == 2 * S + 1) eop = m_acc ? 3'd6 : 3'd5;
      else eop = 3'd2;
      if (t >= 1 && t <= S) erx = m_a[t-1];
      else if (t > S && t <= 2 * S) erx = m_b[t-S-1];
      else erx = 1'b0;
      chk("busy", 64'(busy), 64'(t != 0));
      chk("done", 64'(done), 64'(t != 0 && t == m_total));
      chk("pe_opcode", 64'(pe_opcode), 64'(eop));
      chk("pe_rx", 64'(pe_rx), 64'(erx));
      if (res_ok) chk("result", 64'(result), 64'(e_res));
      if (ea_ok) chk("echo_a", 64'(echo_a), 64'(e_ea));
      if (eb_ok) chk("echo_b", 64'(echo_b), 64'(e_eb));
    end
  end

  task automatic run_cmd(input logic [S-1:0] a, input logic [S-1:0] b, input logic acc,
                         input logic rd, input int glitch, output int bc,
                         output logic [AW-1:0] res);
    bit got;
    got = 0;
    @(posedge clk); #1;
    a_in = a; b_in = b; cmd_acc = acc; cmd_read = rd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a_in = ~a; b_in = ~b; cmd_acc = ~acc; cmd_read = ~rd;
    bc  = 0;
    res = 'x;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin
        got = 1;
        res = result;
        start = 1'b0;
      end else if (glitch != 0 && bc == glitch) begin
        start = 1'b1; a_in = 8'h09; b_in = 8'h09; cmd_acc = 1'b1; cmd_read = 1'b0;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("done_seen", 64'(got), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bc;
    int dcnt;
    logic [AW-1:0] res;

    rst = 1'b1; start = 1'b0; cmd_acc = 1'b0; cmd_read = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1;
    @(negedge clk);
    chk("rst_opcode", 64'(pe_opcode), 64'd7);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_done", 64'(done), 64'd0);

    run_cmd(8'd3, 8'd5, 1'b0, 1'b1, 0, bc, res);
    chk("mul_busy_cycles", 64'(bc), 64'd50);
    chk("mul_result", 64'(res), 64'd15);

    run_cmd(8'd3, 8'd5, 1'b0, 1'b0, 0, bc, res);
    chk("noread_busy_cycles", 64'(bc), 64'd18);
    chk("noread_result_held", 64'(res), 64'd15);

    run_cmd(8'd2, 8'd7, 1'b1, 1'b1, 0, bc, res);
    chk("mac_result", 64'(res), 64'd29);

    run_cmd(8'hFF, 8'hFF, 1'b0, 1'b1, 0, bc, res);
    chk("extreme_result", 64'(res), 64'hFE01);

    run_cmd(8'h00, 8'h00, 1'b1, 1'b1, 0, bc, res);
    chk("destructive_read", 64'(res), 64'd0);

    run_cmd(8'd4, 8'd6, 1'b0, 1'b1, 10, bc, res);
    chk("glitch_busy_cycles", 64'(bc), 64'd50);
    chk("glitch_result", 64'(res), 64'd24);

    // Abort during LOAD2.
    @(posedge clk); #1;
    a_in = 8'h11; b_in = 8'h22; cmd_acc = 1'b0; cmd_read = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (S + 2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_opcode", 64'(pe_opcode), 64'd7);
    chk("abort_result", 64'(result), 64'd0);
    dcnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("abort_no_done", 64'(dcnt), 64'd0);

    run_cmd(8'h12, 8'h34, 1'b0, 1'b0, 0, bc, res);
    run_cmd(8'h56, 8'h78, 1'b0, 1'b0, 0, bc, res);
    chk("echo_result_held", 64'(res), 64'd0);
`ifdef PDATA_SEQ_ECHO_EN
    chk("echo_a_prev", 64'(echo_a), 64'h12);
    chk("echo_b_prev", 64'(echo_b), 64'h34);
`else
    chk("echo_a_tied", 64'(echo_a), 64'h0);
    chk("echo_b_tied", 64'(echo_b), 64'h0);
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
